// File: rtl/z80_bus_responder.sv
// Z80 bus slave: decodes a memory window and an I/O port range, forwards the
// access to a handshaked backend with wait states and timeout, and answers IM2 acks.
module z80_bus_responder #(
  parameter logic [15:0] MEM_MATCH  = 16'h8000,
  parameter logic [15:0] MEM_MASK   = 16'hC000,
  parameter logic [7:0]  IO_MATCH   = 8'h10,
  parameter logic [7:0]  IO_MASK    = 8'hF0,
  parameter logic [7:0]  IM2_VECTOR = 8'hE0,
  parameter int          TIMEOUT    = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] A,
  input  logic [7:0]  di,
  output logic [7:0]  dout,
  output logic        doe,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  output logic        wait_n,
  output logic        int_n,
  input  logic        irq,
  output logic        be_req,
  output logic        be_we,
  output logic        be_io,
  output logic [15:0] be_addr,
  output logic [7:0]  be_wdata,
  input  logic [7:0]  be_rdata,
  input  logic        be_ack,
  output logic        err
);

  // state   | meaning
  // IDLE    | waiting for a decoded access or an interrupt acknowledge
  // REQ     | first cycle of a backend request
  // RESP    | backend request outstanding, timeout counting down
  // HOLD    | backend done; drive read data until the CPU releases its strobes
  // RELEASE | interrupt acknowledge answered; wait for iorq_n/m1_n to rise
  typedef enum logic [2:0] {S_IDLE, S_REQ, S_RESP, S_HOLD, S_RELEASE} state_t;

  localparam logic [7:0] TO_LOAD = 8'(TIMEOUT - 1);

  state_t     state, state_nxt;
  logic       mem_sel, io_sel, ack_sel, any_sel, strobes_idle;
  logic       busy, to_hit, timeout_evt, ack_take;
  logic       irq_q, irq_rise, pending;
  logic [7:0] to_cnt;
  logic [7:0] rdata_q;

  assign mem_sel = !mreq_n && rfsh_n && (!rd_n || !wr_n) && ((A & MEM_MASK) == MEM_MATCH);
  assign io_sel  = !iorq_n && m1_n && (!rd_n || !wr_n) && ((A[7:0] & IO_MASK) == IO_MATCH);
  assign ack_sel = !iorq_n && !m1_n;
  assign any_sel = mem_sel || io_sel;
  assign strobes_idle = rd_n && wr_n && mreq_n && iorq_n;

  assign busy        = (state == S_REQ) || (state == S_RESP);
  assign to_hit      = (to_cnt == 8'd0);
  assign timeout_evt = busy && !be_ack && to_hit;
  assign ack_take    = (state == S_IDLE) && !any_sel && ack_sel && pending;
  assign irq_rise    = irq && !irq_q;

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (any_sel)                state_nxt = S_REQ;
        else if (ack_sel && pending) state_nxt = S_RELEASE;
      end
      S_REQ, S_RESP: begin
        if (be_ack || to_hit) state_nxt = S_HOLD;
        else                  state_nxt = S_RESP;
      end
      S_HOLD:    if (strobes_idle)    state_nxt = S_IDLE;
      S_RELEASE: if (iorq_n && m1_n)  state_nxt = S_IDLE;
      default:   state_nxt = S_IDLE;
    endcase
  end

  // irq_q keeps tracking through reset so a level already high is not an edge
  always_ff @(posedge clk) begin
    irq_q <= irq;
    if (reset) begin
      pending  <= 1'b0;
      to_cnt   <= 8'd0;
      be_addr  <= 16'h0000;
      be_we    <= 1'b0;
      be_io    <= 1'b0;
      be_wdata <= 8'h00;
      rdata_q  <= 8'h00;
      err      <= 1'b0;
    end else begin
      pending <= irq_rise || (pending && !ack_take);
      err     <= timeout_evt;
      if ((state == S_IDLE) && any_sel) begin
        be_addr  <= mem_sel ? A : {8'h00, A[7:0]};
        be_io    <= !mem_sel;
        be_we    <= !wr_n;
        be_wdata <= di;
        to_cnt   <= TO_LOAD;
      end else if (busy && !to_hit) begin
        to_cnt <= to_cnt - 8'd1;
      end
      if (busy && be_ack && !be_we) rdata_q <= be_rdata;
      else if (timeout_evt)         rdata_q <= 8'hFF;
    end
  end

  assign be_req = busy;
  assign int_n  = !pending;

  always_comb begin
    wait_n = 1'b1;
    doe    = 1'b0;
    dout   = 8'h00;
    if (!reset) begin
      if (any_sel && ((state == S_IDLE) || busy)) wait_n = 1'b0;
      case (state)
        S_HOLD: if (!be_we && !strobes_idle) begin
          doe  = 1'b1;
          dout = rdata_q;
        end
        S_IDLE: if (ack_take) begin
          doe  = 1'b1;
          dout = IM2_VECTOR;
        end
        S_RELEASE: if (ack_sel) begin
          doe  = 1'b1;
          dout = IM2_VECTOR;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_z80_bus_responder.sv
// Directed bench for z80_bus_responder: a transaction-level model is compared
// against the DUT on every negedge, plus literal checks inside each scenario.
module tb_z80_bus_responder;
  localparam int TIMEOUT = 16;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] A = 16'h0000;
  logic [7:0]  di = 8'h00;
  logic [7:0]  dout;
  logic        doe;
  logic        m1_n = 1'b1, mreq_n = 1'b1, iorq_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, rfsh_n = 1'b1;
  logic        wait_n, int_n;
  logic        irq = 1'b1;
  logic        be_req, be_we, be_io;
  logic [15:0] be_addr;
  logic [7:0]  be_wdata;
  logic [7:0]  be_rdata = 8'h00;
  logic        be_ack = 1'b0;
  logic        err;

  z80_bus_responder #(.TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .A(A), .di(di), .dout(dout), .doe(doe),
    .m1_n(m1_n), .mreq_n(mreq_n), .iorq_n(iorq_n), .rd_n(rd_n), .wr_n(wr_n), .rfsh_n(rfsh_n),
    .wait_n(wait_n), .int_n(int_n), .irq(irq),
    .be_req(be_req), .be_we(be_we), .be_io(be_io), .be_addr(be_addr), .be_wdata(be_wdata),
    .be_rdata(be_rdata), .be_ack(be_ack), .err(err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  bit          model_valid = 0;
  bit          m_busy, m_hold, m_rel, m_pend, m_err, m_we, m_io, m_irq_prev;
  int          m_cnt;
  logic [15:0] m_addr;
  logic [7:0]  m_wdata, m_data;

  function automatic bit f_mem();
    return !mreq_n && rfsh_n && (!rd_n || !wr_n) && ((A & 16'hC000) == 16'h8000);
  endfunction
  function automatic bit f_io();
    return !iorq_n && m1_n && (!rd_n || !wr_n) && ((A[7:0] & 8'hF0) == 8'h10);
  endfunction
  function automatic bit f_ack();
    return !iorq_n && !m1_n;
  endfunction

  initial begin
    bit ms, is_, as, rise, clr, idle;
    forever begin
      @(posedge clk);
      ms = f_mem(); is_ = f_io(); as = f_ack();
      if (reset) begin
        m_busy = 0; m_hold = 0; m_rel = 0; m_pend = 0; m_err = 0;
        m_we = 0; m_io = 0; m_addr = 16'h0; m_wdata = 8'h0; m_data = 8'h0; m_cnt = 0;
        m_irq_prev = irq;
      end else begin
        rise = irq && !m_irq_prev;
        m_irq_prev = irq;
        clr = 0;
        m_err = 0;
        idle = !m_busy && !m_hold && !m_rel;
        if (idle) begin
          if (ms || is_) begin
            m_addr = ms ? A : {8'h00, A[7:0]};
            m_io = !ms; m_we = !wr_n; m_wdata = di;
            m_busy = 1; m_cnt = 0;
          end else if (as && m_pend) begin
            m_rel = 1; clr = 1;
          end
        end else if (m_busy) begin
          m_cnt++;
          if (be_ack) begin
            m_busy = 0; m_hold = 1;
            if (!m_we) m_data = be_rdata;
          end else if (m_cnt == TIMEOUT) begin
            m_busy = 0; m_hold = 1; m_data = 8'hFF; m_err = 1;
          end
        end else if (m_hold) begin
          if (rd_n && wr_n && mreq_n && iorq_n) m_hold = 0;
        end else if (m_rel) begin
          if (iorq_n && m1_n) m_rel = 0;
        end
        if (rise) m_pend = 1;
        else if (clr) m_pend = 0;
      end
      model_valid = 1;
    end
  end

  int err_pulses = 0;
  int req_rises = 0;
  bit req_prev = 0;

  initial begin
    bit ms, is_, as, idle, e_wait, e_doe;
    logic [7:0] e_dout;
    forever begin
      @(negedge clk);
      if (model_valid) begin
        ms = f_mem(); is_ = f_io(); as = f_ack();
        idle = !m_busy && !m_hold && !m_rel;
        e_wait = reset ? 1'b1 : !((ms || is_) && (idle || m_busy));
        e_doe = 0; e_dout = 8'h00;
        if (!reset) begin
          if (m_hold && !m_we && !(rd_n && wr_n && mreq_n && iorq_n)) begin
            e_doe = 1; e_dout = m_data;
          end else if ((idle && !(ms || is_) && as && m_pend) || (m_rel && as)) begin
            e_doe = 1; e_dout = 8'hE0;
          end
        end
        chk("be_req", be_req, m_busy);
        chk("be_we", be_we, m_we);
        chk("be_io", be_io, m_io);
        chk("be_addr", be_addr, m_addr);
        chk("be_wdata", be_wdata, m_wdata);
        chk("err", err, m_err);
        chk("int_n", int_n, !m_pend);
        chk("wait_n", wait_n, e_wait);
        chk("doe", doe, e_doe);
        chk("dout", dout, e_dout);
        if (err === 1'b1) err_pulses++;
        if (be_req === 1'b1 && !req_prev) req_rises++;
        req_prev = (be_req === 1'b1);
      end
    end
  end

  // ---------------- backend responder ----------------
  bit ack_en = 1;
  int ack_delay = 3;
  bit late_ack = 0;
  initial begin
    int seen;
    seen = 0;
    forever begin
      @(posedge clk);
      #2;
      if (be_req && ack_en) begin
        seen++;
        be_ack = (seen == ack_delay);
      end else begin
        seen = 0;
        be_ack = late_ack;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic release_bus();
    m1_n = 1; mreq_n = 1; iorq_n = 1; rd_n = 1; wr_n = 1; rfsh_n = 1;
  endtask

  task automatic cpu_cycle(input logic [15:0] addr, input bit io, input bit wr,
                           input logic [7:0] wd, input bit exp_read, input logic [7:0] exp_rd);
    int n;
    bit done;
    A = addr; di = wd;
    if (io) iorq_n = 0; else mreq_n = 0;
    if (wr) wr_n = 0; else rd_n = 0;
    n = 0; done = 0;
    while (!done) begin
      tick(1);
      n++;
      if (wait_n) done = 1;
      else if (n >= 100) begin
        chk("wait_bound", {31'h0, wait_n}, 32'h1);
        done = 1;
      end
    end
    if (exp_read) begin
      chk("rd_doe", doe, 1'b1);
      chk("rd_dout", dout, exp_rd);
    end else begin
      chk("no_doe", doe, 1'b0);
    end
    tick(1);
    release_bus();
    tick(2);
  endtask

  int r0, e0;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    tick(3);
    chk("rst_be_req", be_req, 1'b0);
    chk("rst_int_n", int_n, 1'b1);
    chk("rst_wait_n", wait_n, 1'b1);
    chk("rst_doe", doe, 1'b0);
    chk("rst_err", err, 1'b0);
    chk("rst_be_addr", be_addr, 16'h0000);
    reset = 0;
    tick(3);
    chk("irq_high_no_pend", int_n, 1'b1);
    irq = 0;
    tick(1);

    // memory read, ack on third request cycle
    r0 = req_rises;
    ack_en = 1; ack_delay = 3; be_rdata = 8'h5A;
    cpu_cycle(16'h8123, 0, 0, 8'h00, 1, 8'h5A);
    chk("mrd_one_req", req_rises - r0, 1);
    chk("mrd_addr", be_addr, 16'h8123);
    chk("mrd_we", be_we, 1'b0);

    // I/O write
    ack_delay = 2;
    cpu_cycle(16'h0013, 1, 1, 8'hC3, 0, 8'h00);
    chk("iow_io", be_io, 1'b1);
    chk("iow_we", be_we, 1'b1);
    chk("iow_addr", be_addr, 16'h0013);
    chk("iow_wdata", be_wdata, 8'hC3);

    // unmapped read and a refresh cycle into the window
    r0 = req_rises;
    cpu_cycle(16'h4000, 0, 0, 8'h00, 0, 8'h00);
    rfsh_n = 0;
    cpu_cycle(16'h8000, 0, 0, 8'h00, 0, 8'h00);
    chk("unmapped_no_req", req_rises - r0, 0);

    // timeout then a normal access at the window edge
    e0 = err_pulses;
    ack_en = 0;
    cpu_cycle(16'h8040, 0, 0, 8'h00, 1, 8'hFF);
    chk("to_err_once", err_pulses - e0, 1);
    ack_en = 1; ack_delay = 1; be_rdata = 8'h3C;
    cpu_cycle(16'hBFFF, 0, 0, 8'h00, 1, 8'h3C);
    chk("after_to_addr", be_addr, 16'hBFFF);

    // I/O read, upper address byte dropped
    be_rdata = 8'h77; ack_delay = 2;
    cpu_cycle(16'hAB1F, 1, 0, 8'h00, 1, 8'h77);
    chk("ior_addr", be_addr, 16'h001F);
    chk("ior_io", be_io, 1'b1);

    // both decodes true: memory wins
    be_rdata = 8'h11;
    iorq_n = 0;
    cpu_cycle(16'h8010, 0, 0, 8'h00, 1, 8'h11);
    chk("prio_io", be_io, 1'b0);
    chk("prio_addr", be_addr, 16'h8010);

    // interrupt request and acknowledge
    irq = 1;
    tick(2);
    chk("irq_int_n", int_n, 1'b0);
    m1_n = 0;
    tick(1);
    iorq_n = 0;
    #1;
    chk("ack_doe", doe, 1'b1);
    chk("ack_dout", dout, 8'hE0);
    tick(1);
    chk("ack_hold_dout", dout, 8'hE0);
    chk("ack_wait_n", wait_n, 1'b1);
    release_bus();
    tick(2);
    chk("ack_int_n", int_n, 1'b1);

    // rising irq in the clearing cycle keeps the request pending
    irq = 0;
    tick(1);
    irq = 1;
    tick(1);
    irq = 0;
    tick(1);
    m1_n = 0; iorq_n = 0; irq = 1;
    tick(1);
    chk("set_wins_int_n", int_n, 1'b0);
    release_bus();
    tick(2);
    m1_n = 0; iorq_n = 0;
    tick(2);
    chk("clear_int_n", int_n, 1'b1);
    release_bus();
    tick(2);
    m1_n = 0; iorq_n = 0;
    tick(1);
    chk("ack_no_pend_doe", doe, 1'b0);
    release_bus();
    tick(2);

    // reset during an outstanding request, then a late ack
    e0 = err_pulses;
    ack_en = 0;
    A = 16'h8010; mreq_n = 0; rd_n = 0;
    tick(5);
    chk("pre_rst_req", be_req, 1'b1);
    reset = 1;
    release_bus();
    tick(1);
    chk("mid_rst_req", be_req, 1'b0);
    chk("mid_rst_wait", wait_n, 1'b1);
    reset = 0;
    late_ack = 1;
    tick(1);
    late_ack = 0;
    tick(3);
    chk("late_ack_req", be_req, 1'b0);
    chk("rst_no_err", err_pulses - e0, 0);

    // normal access after the abort
    ack_en = 1; ack_delay = 2; be_rdata = 8'hA5;
    cpu_cycle(16'h8200, 0, 0, 8'h00, 1, 8'hA5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
